// File: rtl/bsg_upstream_pkg.sv
// rtl/bsg_upstream_pkg.sv - shared types and geometry helpers for the credit-based upstream serialiser
package bsg_upstream_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int beat_width(input int num_ch, input int ch_w);
    return num_ch * ch_w;
  endfunction

  function automatic int beat_count(input int data_w, input int beat_w);
    return data_w / beat_w;
  endfunction

  // A word must split into at least two whole beats, and tokens must tile the credit pool.
  function automatic bit geometry_ok(input int data_w, input int beat_w,
                                     input int credits, input int token_dec);
    return (beat_w > 0) && (token_dec > 0) && (data_w % beat_w == 0) &&
           (data_w / beat_w >= 2) && (credits % token_dec == 0);
  endfunction

endpackage

// File: rtl/bsg_credit_counter.sv
// rtl/bsg_credit_counter.sv - saturating credit counter with sticky overflow flag
module bsg_credit_counter #(
  parameter int CREDITS_P   = 32,
  parameter int TOKEN_DEC_P = 8,
  parameter int CRED_W      = $clog2(CREDITS_P + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec,
  input  logic              inc,
  output logic [CRED_W-1:0] credit,
  output logic              err
);

  localparam int SUM_W = $clog2(CREDITS_P + TOKEN_DEC_P + 1);

  logic [SUM_W-1:0] sum;
  logic             overflow;

  // dec is only asserted while credit is nonzero, so the sum never underflows.
  always_comb begin
    sum      = SUM_W'(credit) + (inc ? SUM_W'(TOKEN_DEC_P) : '0) - SUM_W'(dec);
    overflow = sum > SUM_W'(CREDITS_P);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= CRED_W'(CREDITS_P);
      err    <= 1'b0;
    end else begin
      credit <= overflow ? CRED_W'(CREDITS_P) : CRED_W'(sum);
      err    <= err | overflow;
    end
  end

endmodule

// File: rtl/bsg_upstream_piso_credit.sv
// rtl/bsg_upstream_piso_credit.sv - serialises core words into credit-gated io beats
module bsg_upstream_piso_credit
  import bsg_upstream_pkg::*;
#(
  parameter  int DATA_W      = 64,
  parameter  int CH_W        = 8,
  parameter  int NUM_CH      = 2,
  parameter  int CREDITS_P   = 32,
  parameter  int TOKEN_DEC_P = 8,
  parameter  int CNT_W       = 7,
  localparam int BEAT_W      = beat_width(NUM_CH, CH_W),
  localparam int BEATS       = beat_count(DATA_W, BEAT_W),
  localparam int CRED_W      = $clog2(CREDITS_P + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_valid_i,
  input  logic [DATA_W-1:0] core_data_i,
  output logic              core_ready_and_o,
  output logic              io_valid_o,
  output logic [BEAT_W-1:0] io_data_o,
  input  logic              io_token_i,
  output logic [CRED_W-1:0] credit_o,
  output logic [CNT_W-1:0]  sent_cnt_o,
  output logic [CNT_W-1:0]  finish_cnt_o,
  output logic              credit_err_o
);

  localparam int BCW = $clog2(BEATS);

  if (!geometry_ok(DATA_W, BEAT_W, CREDITS_P, TOKEN_DEC_P)) begin : g_bad_geometry
    $error("bsg_upstream_piso_credit: illegal DATA_W/beat or CREDITS_P/TOKEN_DEC_P geometry");
  end

  state_e            state;
  logic [DATA_W-1:0] shift_reg;
  logic [BCW-1:0]    beat_ctr;
  logic              fire;
  logic              last;
  logic              accept;

  assign io_valid_o = (state == SHIFT) && (credit_o != '0);
  assign fire       = io_valid_o;
  assign last       = beat_ctr == BCW'(BEATS - 1);
  // Ready while the last beat leaves lets the next word reload with no idle cycle.
  assign core_ready_and_o = (state == IDLE) || (fire && last);
  assign accept     = core_valid_i && core_ready_and_o;
  assign io_data_o  = shift_reg[BEAT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      beat_ctr  <= '0;
    end else if (accept) begin
      state     <= SHIFT;
      shift_reg <= core_data_i;
      beat_ctr  <= '0;
    end else if (fire) begin
      shift_reg <= shift_reg >> BEAT_W;
      beat_ctr  <= beat_ctr + BCW'(1);
      if (last) state <= IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_cnt_o   <= '0;
      finish_cnt_o <= '0;
    end else begin
      if (fire) sent_cnt_o <= sent_cnt_o + CNT_W'(1);
      if (io_token_i) finish_cnt_o <= finish_cnt_o + CNT_W'(TOKEN_DEC_P);
    end
  end

  bsg_credit_counter #(
    .CREDITS_P  (CREDITS_P),
    .TOKEN_DEC_P(TOKEN_DEC_P),
    .CRED_W     (CRED_W)
  ) u_credit (
    .clk   (clk),
    .rst_n (rst_n),
    .dec   (fire),
    .inc   (io_token_i),
    .credit(credit_o),
    .err   (credit_err_o)
  );

endmodule
